// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload responder.
package nvram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LAT,
        ST_PRESENT
    } nv_state_e;

    localparam logic [7:0] NV_INDEX_DEF = 8'd4;
    localparam logic [7:0] OOR_FILL     = 8'hFF;

endpackage

// File: rtl/nvram_dirty_timer.sv
// Dirty flag and quiet-period timer; pulses upload_req once CMOS writes have been idle long enough.
module nvram_dirty_timer #(
    parameter int unsigned QUIET_CYCLES = 48_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic nv_we,
    input  logic ioctl_upload,
    output logic upload_req
);

    localparam int unsigned CNT_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUIET_CYCLES - 1);

    logic             dirty;
    logic [CNT_W-1:0] quiet_cnt;

    // A write always wins over expiry, so the count restarts from that write.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dirty      <= 1'b0;
            quiet_cnt  <= '0;
            upload_req <= 1'b0;
        end else if (nv_we) begin
            dirty      <= 1'b1;
            quiet_cnt  <= '0;
            upload_req <= 1'b0;
        end else if (dirty && !ioctl_upload) begin
            if (quiet_cnt == CNT_LAST) begin
                dirty      <= 1'b0;
                quiet_cnt  <= '0;
                upload_req <= 1'b1;
            end else begin
                quiet_cnt  <= quiet_cnt + CNT_W'(1);
                upload_req <= 1'b0;
            end
        end else begin
            upload_req <= 1'b0;
        end
    end

endmodule

// File: rtl/nvram_uploader.sv
// Serves CMOS byte reads to hps_io during ioctl_upload; optional autosave request
// is built when NVRAM_AUTOSAVE_EN is defined.
module nvram_uploader
    import nvram_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 4,
    parameter logic [7:0]  NV_INDEX     = NV_INDEX_DEF,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned QUIET_CYCLES = 48_000_000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic [16:0]       ioctl_addr,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    output logic [ADDR_W-1:0] nv_addr,
    output logic              nv_rd,
    input  logic [DATA_W-1:0] nv_q,
    input  logic              nv_we,
    output logic              busy
);

    localparam int unsigned LAT_W = 3;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 2);

    nv_state_e         state_q, state_d;
    logic [7:0]        din_d;
    logic              wait_d;
    logic              nv_rd_d;
    logic [ADDR_W-1:0] nv_addr_d;
    logic              busy_d;
    logic              oor_q, oor_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              addr_oor_c;

    assign addr_oor_c = (ADDR_W < 17) ? (32'(ioctl_addr) >= (32'd1 << ADDR_W)) : 1'b0;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            nv_rd      <= 1'b0;
            nv_addr    <= '0;
            busy       <= 1'b0;
            oor_q      <= 1'b0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ioctl_din  <= din_d;
            ioctl_wait <= wait_d;
            nv_rd      <= nv_rd_d;
            nv_addr    <= nv_addr_d;
            busy       <= busy_d;
            oor_q      <= oor_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    // Next-state and next-output logic; registered outputs are loaded one state early.
    always_comb begin
        state_d   = state_q;
        din_d     = ioctl_din;
        wait_d    = ioctl_wait;
        nv_rd_d   = 1'b0;
        nv_addr_d = nv_addr;
        oor_d     = oor_q;
        lat_cnt_d = lat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ioctl_rd && ioctl_upload && (ioctl_index == NV_INDEX)) begin
                    state_d   = ST_ISSUE;
                    wait_d    = 1'b1;
                    oor_d     = addr_oor_c;
                    nv_rd_d   = !addr_oor_c;
                    nv_addr_d = ADDR_W'(ioctl_addr);
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = '0;
                state_d   = (RD_LAT > 1) ? ST_LAT : ST_PRESENT;
            end
            ST_LAT: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                din_d   = oor_q ? OOR_FILL : 8'(nv_q);
                wait_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Upload ending mid-access abandons it and keeps the last returned byte.
        if ((state_q != ST_IDLE) && !ioctl_upload) begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
            nv_rd_d = 1'b0;
            din_d   = ioctl_din;
        end

        busy_d = (state_d != ST_IDLE);
    end

`ifdef NVRAM_AUTOSAVE_EN
    nvram_dirty_timer #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_dirty_timer (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .nv_we        (nv_we),
        .ioctl_upload (ioctl_upload),
        .upload_req   (ioctl_upload_req)
    );
`else
    logic unused_autosave;
    assign unused_autosave  = nv_we ^ (QUIET_CYCLES == 0);
    assign ioctl_upload_req = 1'b0;
`endif

endmodule
